// File: rtl/mcp23s17_spi_sequencer.sv
// MCP23S17 SPI mode-0 register sequencer: one 3-byte frame per request.
// Define MCP_AUTO_INIT_EN to run the IOCON/IODIRA setup frames after reset.
module mcp23s17_spi_sequencer #(
    parameter int CLK_DIV      = 4,
    parameter int CS_SETUP_CYC = 4,
    parameter int CS_HOLD_CYC  = 4,
    parameter int CS_GAP_CYC   = 8
) (
    input  logic       sysClk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [2:0] req_hw_addr,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       spiClk,
    output logic       cs,
    output logic       mosi,
    input  logic       miso
);

    localparam int MAX_A = (CLK_DIV > CS_SETUP_CYC) ? CLK_DIV : CS_SETUP_CYC;
    localparam int MAX_B = (CS_HOLD_CYC > CS_GAP_CYC) ? CS_HOLD_CYC : CS_GAP_CYC;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W = $clog2(MAX_P);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_GAP_CYC - 1);

`ifdef MCP_AUTO_INIT_EN
    localparam logic [1:0] INIT_N = 2'd2;
`else
    localparam logic [1:0] INIT_N = 2'd0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LOW,
        S_HIGH,
        S_HOLD,
        S_GAP
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_bit;
    logic [23:0]      r_frame;
    logic [7:0]       r_rx;
    logic             r_rw;
    logic             r_init_frm;
    logic [1:0]       r_init_left;
    logic             r_miso_s1;
    logic             r_miso_s2;
    logic             r_req_ready;
    logic             r_rsp_valid;
    logic [7:0]       r_rsp_rdata;
    logic             r_busy;
    logic             r_spiClk;
    logic             r_cs;
    logic             r_mosi;

    logic             w_use_init;
    logic             w_start;
    logic [23:0]      w_frame;

    // Pending init frames take priority over any external request.
    always_comb begin
        w_use_init = (r_init_left != 2'd0);
        w_start    = (r_state == S_IDLE) &&
                     (w_use_init || (req_valid && r_req_ready));
        w_frame    = {4'b0100, req_hw_addr, req_rw, req_reg,
                      req_rw ? 8'h00 : req_wdata};
        if (w_use_init) begin
            w_frame = (r_init_left == 2'd2) ? 24'h400A08 : 24'h400000;
        end
    end

    always_ff @(posedge sysClk) begin
        if (reset) begin
            r_miso_s1 <= 1'b0;
            r_miso_s2 <= 1'b0;
        end else begin
            r_miso_s1 <= miso;
            r_miso_s2 <= r_miso_s1;
        end
    end

    always_ff @(posedge sysClk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit       <= 5'd0;
            r_frame     <= 24'h0;
            r_rx        <= 8'h00;
            r_rw        <= 1'b0;
            r_init_frm  <= 1'b0;
            r_init_left <= INIT_N;
            r_req_ready <= (INIT_N == 2'd0);
            r_busy      <= (INIT_N != 2'd0);
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 8'h00;
            r_spiClk    <= 1'b0;
            r_cs        <= 1'b1;
            r_mosi      <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state     <= S_SETUP;
                        r_cnt       <= '0;
                        r_bit       <= 5'd23;
                        r_frame     <= w_frame;
                        r_mosi      <= w_frame[23];
                        r_cs        <= 1'b0;
                        r_spiClk    <= 1'b0;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_init_frm  <= w_use_init;
                        r_rw        <= w_use_init ? 1'b0 : req_rw;
                        if (w_use_init) begin
                            r_init_left <= r_init_left - 2'd1;
                        end
                    end
                end
                S_SETUP: begin
                    if (r_cnt == SETUP_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_LOW;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_LOW: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt    <= '0;
                        r_spiClk <= 1'b1;
                        r_state  <= S_HIGH;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (r_cnt == HALF_LAST) begin
                        // Late sample absorbs synchroniser and slave latency.
                        r_cnt    <= '0;
                        r_rx     <= {r_rx[6:0], r_miso_s2};
                        r_spiClk <= 1'b0;
                        if (r_bit == 5'd0) begin
                            r_state <= S_HOLD;
                        end else begin
                            r_bit   <= r_bit - 5'd1;
                            r_mosi  <= r_frame[r_bit - 5'd1];
                            r_state <= S_LOW;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_cnt       <= '0;
                        r_cs        <= 1'b1;
                        r_mosi      <= 1'b0;
                        r_rsp_valid <= ~r_init_frm;
                        if (r_rw && !r_init_frm) begin
                            r_rsp_rdata <= r_rx;
                        end
                        r_state <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt       <= '0;
                        r_state     <= S_IDLE;
                        r_req_ready <= (r_init_left == 2'd0);
                        r_busy      <= (r_init_left != 2'd0);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign busy      = r_busy;
    assign spiClk    = r_spiClk;
    assign cs        = r_cs;
    assign mosi      = r_mosi;

endmodule
